// File: rtl/ex_mem_pipe_reg.sv
// ex_mem_pipe_reg
//
// EX->MEM pipeline stage register with valid/ready flow control, a one-entry
// skid buffer, flush (bubble insertion) and a forwarding-status output.
//
// ex_ready depends only on the state register and rst. It never depends on
// mem_ready, so MEM stalls do not create a combinational path back into EX.
// The skid entry absorbs the one beat that EX may launch in the cycle
// mem_ready drops.
//
// Parameters
//   DATA_W  width of ALU result and store data
//   WREG_W  width of destination register index
//   CTRL_W  control bundle width (>= 4):
//             bit 0 MemtoReg, 1 RegWrite, 2 MemRead, 3 MemWrite, rest pass-through
//
// Ports
//   clk, rst        rising-edge clock; synchronous active-high reset
//   ex_valid        EX presents an instruction
//   ex_ready        stage can accept this cycle
//   ex_ctrl         control bundle from EX
//   ex_alu_res      ALU result / address from EX
//   ex_rdata2       store data from EX
//   ex_wreg         destination register from EX
//   flush           squash all held and incoming instructions
//   mem_valid       MEM-side instruction valid
//   mem_ready       MEM consumes this cycle
//   mem_ctrl        control bundle, forced to zero when not valid
//   mem_alu_res     held ALU result (main entry, shown regardless of valid)
//   mem_rdata2      held store data (main entry, shown regardless of valid)
//   mem_wreg        held destination register (main entry, shown regardless of valid)
//   mem_fwd_en      main entry is a valid forwarding source
//   occupancy       number of held entries, 0..2

module ex_mem_pipe_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned WREG_W = 5,
  parameter int unsigned CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [CTRL_W-1:0] ex_ctrl,
  input  logic [DATA_W-1:0] ex_alu_res,
  input  logic [DATA_W-1:0] ex_rdata2,
  input  logic [WREG_W-1:0] ex_wreg,

  input  logic              flush,

  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [CTRL_W-1:0] mem_ctrl,
  output logic [DATA_W-1:0] mem_alu_res,
  output logic [DATA_W-1:0] mem_rdata2,
  output logic [WREG_W-1:0] mem_wreg,
  output logic              mem_fwd_en,
  output logic [1:0]        occupancy
);

  // Bit position of RegWrite in the control bundle.
  localparam int unsigned CtrlRegWrite = 1;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StFull  = 2'd1,
    StSkid  = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Main entry: drives the mem_* outputs.
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_alu_q,  main_alu_d;
  logic [DATA_W-1:0] main_rd2_q,  main_rd2_d;
  logic [WREG_W-1:0] main_wreg_q, main_wreg_d;

  // Skid entry: holds the beat accepted while MEM was stalled.
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_alu_q,  skid_alu_d;
  logic [DATA_W-1:0] skid_rd2_q,  skid_rd2_d;
  logic [WREG_W-1:0] skid_wreg_q, skid_wreg_d;

  logic in_fire;
  logic out_fire;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  always_comb begin
    ex_ready  = !rst && (state_q != StSkid);
    mem_valid = (state_q != StEmpty);
    in_fire   = ex_valid && ex_ready;
    out_fire  = mem_valid && mem_ready;
  end

  // ---------------------------------------------------------------------------
  // Next-state and entry update
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_alu_d  = main_alu_q;
    main_rd2_d  = main_rd2_q;
    main_wreg_d = main_wreg_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_alu_d  = skid_alu_q;
    skid_rd2_d  = skid_rd2_q;
    skid_wreg_d = skid_wreg_q;

    if (flush) begin
      // Any beat accepted this cycle is dropped. Entry contents are left
      // untouched so that a squashed beat never shows up on mem_*.
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_fire) begin
            state_d     = StFull;
            main_ctrl_d = ex_ctrl;
            main_alu_d  = ex_alu_res;
            main_rd2_d  = ex_rdata2;
            main_wreg_d = ex_wreg;
          end
        end

        StFull: begin
          if (out_fire && in_fire) begin
            main_ctrl_d = ex_ctrl;
            main_alu_d  = ex_alu_res;
            main_rd2_d  = ex_rdata2;
            main_wreg_d = ex_wreg;
          end else if (out_fire) begin
            state_d = StEmpty;
          end else if (in_fire) begin
            state_d     = StSkid;
            skid_ctrl_d = ex_ctrl;
            skid_alu_d  = ex_alu_res;
            skid_rd2_d  = ex_rdata2;
            skid_wreg_d = ex_wreg;
          end
        end

        StSkid: begin
          // ex_ready is low here, so only the output side can move.
          if (out_fire) begin
            state_d     = StFull;
            main_ctrl_d = skid_ctrl_q;
            main_alu_d  = skid_alu_q;
            main_rd2_d  = skid_rd2_q;
            main_wreg_d = skid_wreg_q;
          end
        end

        default: begin
          state_d = StEmpty;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers (rst has priority over flush)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StEmpty;
      main_ctrl_q <= '0;
      main_alu_q  <= '0;
      main_rd2_q  <= '0;
      main_wreg_q <= '0;
      skid_ctrl_q <= '0;
      skid_alu_q  <= '0;
      skid_rd2_q  <= '0;
      skid_wreg_q <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_alu_q  <= main_alu_d;
      main_rd2_q  <= main_rd2_d;
      main_wreg_q <= main_wreg_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_alu_q  <= skid_alu_d;
      skid_rd2_q  <= skid_rd2_d;
      skid_wreg_q <= skid_wreg_d;
    end
  end

  // ---------------------------------------------------------------------------
  // MEM-side outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // A bubble must never assert RegWrite/MemRead/MemWrite or any extra bit.
    mem_ctrl    = mem_valid ? main_ctrl_q : '0;
    mem_alu_res = main_alu_q;
    mem_rdata2  = main_rd2_q;
    mem_wreg    = main_wreg_q;
    mem_fwd_en  = mem_valid && main_ctrl_q[CtrlRegWrite] && (main_wreg_q != '0);

    unique case (state_q)
      StEmpty: occupancy = 2'd0;
      StFull:  occupancy = 2'd1;
      StSkid:  occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Directed testbench for ex_mem_pipe_reg. Inputs change 1 time unit after a
// rising edge; outputs are checked there as well, away from the edge.

module tb_ex_mem_pipe_reg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned WREG_W = 5;
  localparam int unsigned CTRL_W = 6;

  logic              clk;
  logic              rst;
  logic              ex_valid;
  logic              ex_ready;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [DATA_W-1:0] ex_alu_res;
  logic [DATA_W-1:0] ex_rdata2;
  logic [WREG_W-1:0] ex_wreg;
  logic              flush;
  logic              mem_valid;
  logic              mem_ready;
  logic [CTRL_W-1:0] mem_ctrl;
  logic [DATA_W-1:0] mem_alu_res;
  logic [DATA_W-1:0] mem_rdata2;
  logic [WREG_W-1:0] mem_wreg;
  logic              mem_fwd_en;
  logic [1:0]        occupancy;

  int errors = 0;
  int checks = 0;

  ex_mem_pipe_reg #(
    .DATA_W (DATA_W),
    .WREG_W (WREG_W),
    .CTRL_W (CTRL_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex_ctrl     (ex_ctrl),
    .ex_alu_res  (ex_alu_res),
    .ex_rdata2   (ex_rdata2),
    .ex_wreg     (ex_wreg),
    .flush       (flush),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_ctrl    (mem_ctrl),
    .mem_alu_res (mem_alu_res),
    .mem_rdata2  (mem_rdata2),
    .mem_wreg    (mem_wreg),
    .mem_fwd_en  (mem_fwd_en),
    .occupancy   (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle 1 unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic [WREG_W-1:0] w);
    ex_valid   = v;
    ex_ctrl    = c;
    ex_alu_res = a;
    ex_rdata2  = d;
    ex_wreg    = w;
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    mem_ready = 1'b0;
    drive(1'b0, '0, '0, '0, '0);

    // ---- Reset: two cycles held ----
    step();
    step();
    chk("rst_mem_valid", 64'(mem_valid), 64'd0);
    chk("rst_mem_ctrl", 64'(mem_ctrl), 64'd0);
    chk("rst_alu", 64'(mem_alu_res), 64'd0);
    chk("rst_rdata2", 64'(mem_rdata2), 64'd0);
    chk("rst_wreg", 64'(mem_wreg), 64'd0);
    chk("rst_fwd", 64'(mem_fwd_en), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_ex_ready", 64'(ex_ready), 64'd0);

    rst = 1'b0;
    #1;
    chk("post_rst_ex_ready", 64'(ex_ready), 64'd1);

    // ---- Stream 4 beats with mem_ready=1 ----
    mem_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 6'b00_0010, DATA_W'(i * 16), DATA_W'(i), WREG_W'(i));
      step();
      chk($sformatf("stream_alu_%0d", i), 64'(mem_alu_res), 64'(i * 16));
      chk($sformatf("stream_occ_%0d", i), 64'(occupancy), 64'd1);
      chk($sformatf("stream_valid_%0d", i), 64'(mem_valid), 64'd1);
    end
    drive(1'b0, '0, '0, '0, '0);
    step();
    chk("stream_drain_occ", 64'(occupancy), 64'd0);
    chk("stream_drain_valid", 64'(mem_valid), 64'd0);

    // ---- Backpressure: A, B, C offered with MEM stalled ----
    mem_ready = 1'b0;
    drive(1'b1, 6'b00_0010, 32'hA1, 32'h0, 5'd1);
    step();
    chk("bp_a_main", 64'(mem_alu_res), 64'hA1);
    chk("bp_a_occ", 64'(occupancy), 64'd1);
    chk("bp_a_ready", 64'(ex_ready), 64'd1);
    drive(1'b1, 6'b00_0010, 32'hB2, 32'h0, 5'd2);
    step();
    chk("bp_b_main", 64'(mem_alu_res), 64'hA1);
    chk("bp_b_occ", 64'(occupancy), 64'd2);
    chk("bp_b_ready", 64'(ex_ready), 64'd0);
    drive(1'b1, 6'b00_0010, 32'hC3, 32'h0, 5'd3);
    step();
    chk("bp_c_held_main", 64'(mem_alu_res), 64'hA1);
    chk("bp_c_held_occ", 64'(occupancy), 64'd2);
    chk("bp_c_held_ready", 64'(ex_ready), 64'd0);
    mem_ready = 1'b1;
    step();
    chk("bp_out_b", 64'(mem_alu_res), 64'hB2);
    chk("bp_out_b_occ", 64'(occupancy), 64'd1);
    chk("bp_ready_back", 64'(ex_ready), 64'd1);
    step();
    chk("bp_out_c", 64'(mem_alu_res), 64'hC3);
    chk("bp_out_c_occ", 64'(occupancy), 64'd1);
    drive(1'b0, '0, '0, '0, '0);
    step();
    chk("bp_drain_occ", 64'(occupancy), 64'd0);

    // ---- Flush while in SKID with an incoming beat ----
    mem_ready = 1'b0;
    drive(1'b1, 6'b11_1111, 32'h51, 32'h0, 5'd4);
    step();
    drive(1'b1, 6'b11_1111, 32'h52, 32'h0, 5'd4);
    step();
    chk("fl_pre_occ", 64'(occupancy), 64'd2);
    flush = 1'b1;
    drive(1'b1, 6'b11_1111, 32'h99, 32'h0, 5'd9);
    step();
    flush = 1'b0;
    drive(1'b0, '0, '0, '0, '0);
    chk("fl_valid", 64'(mem_valid), 64'd0);
    chk("fl_ctrl", 64'(mem_ctrl), 64'd0);
    chk("fl_occ", 64'(occupancy), 64'd0);
    chk("fl_no_99", 64'(mem_alu_res), 64'h51);
    chk("fl_ready", 64'(ex_ready), 64'd1);
    mem_ready = 1'b1;
    step();
    chk("fl_after_occ", 64'(occupancy), 64'd0);
    chk("fl_after_valid", 64'(mem_valid), 64'd0);

    // ---- Forwarding status ----
    drive(1'b1, 6'b00_0010, 32'h60, 32'h0, 5'd5);
    step();
    chk("fwd_wreg5", 64'(mem_fwd_en), 64'd1);
    chk("fwd_ctrl", 64'(mem_ctrl), 64'h02);
    drive(1'b1, 6'b00_0010, 32'h61, 32'h0, 5'd0);
    step();
    chk("fwd_wreg0", 64'(mem_fwd_en), 64'd0);
    drive(1'b1, 6'b00_0001, 32'h62, 32'h0, 5'd5);
    step();
    chk("fwd_no_regwrite", 64'(mem_fwd_en), 64'd0);

    // ---- Bubble gating, including extra ctrl bits ----
    drive(1'b1, 6'b11_1111, 32'h77, 32'h1234, 5'd7);
    step();
    chk("bub_ctrl_live", 64'(mem_ctrl), 64'h3F);
    chk("bub_rdata2", 64'(mem_rdata2), 64'h1234);
    chk("bub_wreg", 64'(mem_wreg), 64'd7);
    drive(1'b0, '0, '0, '0, '0);
    step();
    chk("bub_ctrl_gated", 64'(mem_ctrl), 64'd0);
    chk("bub_valid", 64'(mem_valid), 64'd0);
    chk("bub_alu_kept", 64'(mem_alu_res), 64'h77);
    chk("bub_fwd", 64'(mem_fwd_en), 64'd0);

    // ---- Reset mid-stream with two held entries ----
    mem_ready = 1'b0;
    drive(1'b1, 6'b00_0010, 32'h81, 32'h5, 5'd3);
    step();
    drive(1'b1, 6'b00_0010, 32'h82, 32'h6, 5'd3);
    step();
    chk("mr_pre_occ", 64'(occupancy), 64'd2);
    rst = 1'b1;
    step();
    chk("mr_valid", 64'(mem_valid), 64'd0);
    chk("mr_ctrl", 64'(mem_ctrl), 64'd0);
    chk("mr_alu", 64'(mem_alu_res), 64'd0);
    chk("mr_rdata2", 64'(mem_rdata2), 64'd0);
    chk("mr_wreg", 64'(mem_wreg), 64'd0);
    chk("mr_occ", 64'(occupancy), 64'd0);
    chk("mr_ex_ready", 64'(ex_ready), 64'd0);
    rst = 1'b0;
    mem_ready = 1'b1;
    drive(1'b0, '0, '0, '0, '0);
    step();
    chk("mr_after_valid", 64'(mem_valid), 64'd0);
    chk("mr_after_alu", 64'(mem_alu_res), 64'd0);
    chk("mr_after_ready", 64'(ex_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
